// File: rtl/mdu_ex.sv
// mdu_ex: multicycle multiply/divide unit holding HI/LO for the EX stage.
// Results are computed at start, held pending, and committed when the busy counter expires.
module mdu_ex (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrEX,
  input  logic [31:0] rsdataEX,
  input  logic [31:0] rtdataEX,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic        is_md,
  output logic [31:0] md_rdata
);
  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic        w_rtype, w_mult, w_multu, w_div, w_divu, w_mfhi, w_mthi, w_mflo, w_mtlo;
  logic        w_isdiv, w_wr_ok;
  logic [5:0]  w_f;
  logic [63:0] w_smul, w_umul, w_res;
  logic [31:0] w_ars, w_art, w_dsr, w_uq, w_ur, w_sq, w_sr, w_udv, w_udq, w_udr;

  assign w_rtype = instrEX[31:26] == 6'd0;
  assign w_f     = instrEX[5:0];
  assign w_mult  = w_rtype && w_f == 6'h18;
  assign w_multu = w_rtype && w_f == 6'h19;
  assign w_div   = w_rtype && w_f == 6'h1A;
  assign w_divu  = w_rtype && w_f == 6'h1B;
  assign w_mfhi  = w_rtype && w_f == 6'h10;
  assign w_mthi  = w_rtype && w_f == 6'h11;
  assign w_mflo  = w_rtype && w_f == 6'h12;
  assign w_mtlo  = w_rtype && w_f == 6'h13;
  assign w_isdiv = w_div || w_divu;
  assign is_md    = w_mult || w_multu || w_isdiv || w_mfhi || w_mthi || w_mflo || w_mtlo;
  assign busy     = r_cnt != 4'd0;
  assign w_wr_ok  = !cancel && !busy;
  assign start    = (w_mult || w_multu || w_isdiv) && w_wr_ok;
  assign md_rdata = w_mfhi ? r_hi : w_mflo ? r_lo : 32'd0;

  // low 64 bits of the sign-extended product equal the signed 64-bit product
  assign w_smul = {{32{rsdataEX[31]}}, rsdataEX} * {{32{rtdataEX[31]}}, rtdataEX};
  assign w_umul = {32'd0, rsdataEX} * {32'd0, rtdataEX};

  // signed divide runs on magnitudes; a zero divisor is swapped for 1 and its result discarded
  assign w_ars = rsdataEX[31] ? -rsdataEX : rsdataEX;
  assign w_art = rtdataEX[31] ? -rtdataEX : rtdataEX;
  assign w_dsr = (w_art == 32'd0) ? 32'd1 : w_art;
  assign w_uq  = w_ars / w_dsr;
  assign w_ur  = w_ars % w_dsr;
  assign w_sq  = (rsdataEX[31] ^ rtdataEX[31]) ? -w_uq : w_uq;
  assign w_sr  = rsdataEX[31] ? -w_ur : w_ur;
  assign w_udv = (rtdataEX == 32'd0) ? 32'd1 : rtdataEX;
  assign w_udq = rsdataEX / w_udv;
  assign w_udr = rsdataEX % w_udv;
  assign w_res = w_mult ? w_smul : w_multu ? w_umul : w_div ? {w_sr, w_sq} : {w_udr, w_udq};

  // r_op: 1 = commit pending result at completion, 2 = divide by zero, leave HI/LO alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_cnt <= 4'd0;
      r_op  <= 2'd0;
    end else begin
      if (start) begin
        r_cnt          <= w_isdiv ? 4'd10 : 4'd5;
        r_op           <= (w_isdiv && rtdataEX == 32'd0) ? 2'd2 : 2'd1;
        {r_phi, r_plo} <= w_res;
      end else if (busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (busy && r_cnt == 4'd1 && r_op == 2'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
      if (w_mthi && w_wr_ok) r_hi <= rsdataEX;
      if (w_mtlo && w_wr_ok) r_lo <= rsdataEX;
    end
  end
endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: randomized and directed checks of mdu_ex against an arithmetic HI/LO model.
module tb_mdu_ex;
  logic        clk = 1'b0, reset = 1'b1, cancel = 1'b0;
  logic [31:0] instrEX = '0, rsdataEX = '0, rtdataEX = '0;
  logic        start, busy, is_md;
  logic [31:0] md_rdata;
  int          n_run = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;

  mdu_ex dut (
    .clk(clk), .reset(reset), .instrEX(instrEX), .rsdataEX(rsdataEX), .rtdataEX(rtdataEX),
    .cancel(cancel), .start(start), .busy(busy), .is_md(is_md), .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [5:0] f);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'd0, mid, f};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input logic c);
    @(negedge clk);
    instrEX = ins; rsdataEX = rs; rtdataEX = rt; cancel = c;
    #1;
  endtask

  task automatic idle;
    drive(32'd0, $urandom, $urandom, 1'b0);
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    drive(enc(F_MFHI), $urandom, $urandom, 1'b0);
    h = md_rdata;
    drive(enc(F_MFLO), $urandom, $urandom, 1'b0);
    l = md_rdata;
  endtask

  task automatic wait_idle(output int nb);
    nb = 0;
    idle;
    while (busy && nb < 20) begin
      nb++;
      idle;
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       output logic st, output int nb);
    drive(enc(f), rs, rt, 1'b0);
    st = start;
    wait_idle(nb);
  endtask

  task automatic model_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    longint a, b;
    longint unsigned ua;
    logic [63:0] u;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    ua = {32'd0, rs};
    if (f == F_MULT) begin
      u = 64'(a * b);
      m_hi = u[63:32]; m_lo = u[31:0];
    end else if (f == F_MULTU) begin
      u = ua * {32'd0, rt};
      m_hi = u[63:32]; m_lo = u[31:0];
    end else if (f == F_DIV && rt != 0) begin
      m_lo = 32'(a / b); m_hi = 32'(a % b);
    end else if (f == F_DIVU && rt != 0) begin
      m_lo = rs / rt; m_hi = rs % rt;
    end else if (f == F_MTHI) m_hi = rs;
    else if (f == F_MTLO) m_lo = rs;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1'b1;
    drive(enc(F_MULT), 32'd5, 32'd7, 1'b0);
    drive(enc(F_MTHI), 32'hDEAD, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0; instrEX = '0;
    #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_run++;
    if ({is_md, start, md_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_bubble: got %h expected 0", {is_md, start, md_rdata});
    end
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {h, l}); end
  endtask

  task automatic test_mult;
    logic [31:0] h, l, rs, rt;
    logic st;
    int nb;
    issue(F_MULT, 32'hFFFFFFFE, 32'd3, st, nb);
    model_md(F_MULT, 32'hFFFFFFFE, 32'd3);
    n_run++;
    if (st !== 1'b1 || nb != 5) begin n_fail++; $display("FAIL mult_timing: got start=%b busy=%0d expected 1/5", st, nb); end
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin n_fail++; $display("FAIL mult_dir: got %h expected FFFFFFFFFFFFFFFA", {h, l}); end
    for (int i = 0; i < 4; i++) begin
      rs = $urandom; rt = $urandom;
      issue(F_MULT, rs, rt, st, nb);
      model_md(F_MULT, rs, rt);
      read_hilo(h, l);
      n_run++;
      if ({h, l} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL mult_rand: got %h expected %h", {h, l}, {m_hi, m_lo}); end
    end
  endtask

  task automatic test_multu;
    logic [31:0] h, l, rs, rt;
    logic st;
    int nb;
    issue(F_MULTU, 32'hFFFFFFFF, 32'd2, st, nb);
    model_md(F_MULTU, 32'hFFFFFFFF, 32'd2);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'h00000001_FFFFFFFE || nb != 5) begin
      n_fail++; $display("FAIL multu_dir: got %h busy=%0d expected 00000001FFFFFFFE/5", {h, l}, nb);
    end
    for (int i = 0; i < 4; i++) begin
      rs = $urandom; rt = $urandom;
      issue(F_MULTU, rs, rt, st, nb);
      model_md(F_MULTU, rs, rt);
      read_hilo(h, l);
      n_run++;
      if ({h, l} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL multu_rand: got %h expected %h", {h, l}, {m_hi, m_lo}); end
    end
  endtask

  task automatic test_div;
    logic [31:0] h, l, rs, rt;
    logic st;
    int nb;
    issue(F_DIV, 32'hFFFFFFF9, 32'd2, st, nb);
    model_md(F_DIV, 32'hFFFFFFF9, 32'd2);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD || nb != 10 || st !== 1'b1) begin
      n_fail++; $display("FAIL div_dir: got %h busy=%0d start=%b expected FFFFFFFFFFFFFFFD/10/1", {h, l}, nb, st);
    end
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, st, nb);
    model_md(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_ovf: got %h expected 0000000080000000", {h, l}); end
    for (int i = 0; i < 6; i++) begin
      rs = $urandom;
      rt = (i % 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i >= 4) rt = -rt;
      if (rt == 0) rt = 32'd3;
      issue((i % 3 == 0) ? F_DIVU : F_DIV, rs, rt, st, nb);
      model_md((i % 3 == 0) ? F_DIVU : F_DIV, rs, rt);
      read_hilo(h, l);
      n_run++;
      if ({h, l} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL div_rand: got %h expected %h", {h, l}, {m_hi, m_lo}); end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] h, l;
    logic st;
    int nb;
    drive(enc(F_MTHI), 32'h11, $urandom, 1'b0);
    drive(enc(F_MTLO), 32'h22, $urandom, 1'b0);
    model_md(F_MTHI, 32'h11, 32'd0);
    model_md(F_MTLO, 32'h22, 32'd0);
    issue(F_DIVU, 32'd7, 32'd0, st, nb);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'h00000011_00000022 || nb != 10 || st !== 1'b1) begin
      n_fail++; $display("FAIL divu_zero: got %h busy=%0d start=%b expected 0000001100000022/10/1", {h, l}, nb, st);
    end
    issue(F_DIV, 32'hFFFFFFFB, 32'd0, st, nb);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'h00000011_00000022 || nb != 10) begin
      n_fail++; $display("FAIL div_zero: got %h busy=%0d expected 0000001100000022/10", {h, l}, nb);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] h, l;
    int nb;
    drive(enc(F_MTHI), 32'hABCD0000, $urandom, 1'b0);
    model_md(F_MTHI, 32'hABCD0000, 32'd0);
    read_hilo(h, l);
    n_run++;
    if (h !== 32'hABCD0000) begin n_fail++; $display("FAIL mthi: got %h expected ABCD0000", h); end
    drive(enc(F_MTLO), 32'h1234, $urandom, 1'b0);
    model_md(F_MTLO, 32'h1234, 32'd0);
    drive(enc(F_MULT), 32'd6, 32'd7, 1'b0);
    model_md(F_MULT, 32'd6, 32'd7);
    drive(enc(F_MFLO), $urandom, $urandom, 1'b0);
    n_run++;
    if (md_rdata !== 32'h1234) begin n_fail++; $display("FAIL mflo_pending: got %h expected 00001234", md_rdata); end
    drive(enc(F_MTLO), 32'h5555, $urandom, 1'b0);
    drive(enc(F_MTHI), 32'h6666, $urandom, 1'b0);
    wait_idle(nb);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'd42) begin n_fail++; $display("FAIL mt_busy: got %h expected 000000000000002A", {h, l}); end
  endtask

  task automatic test_cancel;
    logic [31:0] h, l;
    logic st;
    int nb;
    drive(enc(F_MULT), 32'd9, 32'd9, 1'b1);
    n_run++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL cancel_start: got %b expected 0", start); end
    idle;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    drive(enc(F_MTHI), 32'd77, $urandom, 1'b1);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL cancel_hilo: got %h expected %h", {h, l}, {m_hi, m_lo}); end
    drive(enc(F_MULT), 32'hFFFFFFFD, 32'd1000, 1'b0);
    st = start;
    model_md(F_MULT, 32'hFFFFFFFD, 32'd1000);
    idle;
    drive(enc(F_MULT), 32'd1, 32'd1, 1'b1);
    n_run++;
    if (start !== 1'b0 || busy !== 1'b1 || st !== 1'b1) begin
      n_fail++; $display("FAIL cancel_mid: got start=%b busy=%b first=%b expected 0/1/1", start, busy, st);
    end
    wait_idle(nb);
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFF448 || nb != 3) begin
      n_fail++; $display("FAIL cancel_complete: got %h busy_left=%0d expected FFFFFFFFFFFFF448/3", {h, l}, nb);
    end
  endtask

  task automatic test_reset_busy;
    logic [31:0] h, l;
    drive(enc(F_DIV), 32'd100, 32'd7, 1'b0);
    idle; idle; idle;
    @(negedge clk);
    reset = 1'b1; instrEX = '0;
    #1;
    n_run++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b expected 1", busy); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_post: got %b expected 0", busy); end
    m_hi = '0; m_lo = '0;
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL rst_busy_hilo: got %h expected 0", {h, l}); end
    for (int i = 0; i < 12; i++) idle;
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL rst_busy_late: got %h expected 0", {h, l}); end
  endtask

  task automatic test_nonmd;
    logic [31:0] ins, h, l;
    logic [5:0] op;
    for (int i = 0; i < 8; i++) begin
      ins = $urandom;
      op = 6'($urandom_range(1, 63));
      if (i % 2) ins = {op, ins[25:6], 6'h18 + 6'(i % 4)};
      else if (ins[31:26] == 6'd0 && (ins[5:2] == 4'b0100 || ins[5:2] == 4'b0110)) ins[5:0] = 6'h20;
      drive(ins, $urandom, $urandom, 1'b0);
      n_run++;
      if ({is_md, start, md_rdata} !== 34'd0) begin
        n_fail++; $display("FAIL nonmd: instr=%h got %h expected 0", ins, {is_md, start, md_rdata});
      end
    end
    idle;
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== {m_hi, m_lo} || busy !== 1'b0) begin
      n_fail++; $display("FAIL nonmd_state: got %h busy=%b expected %h/0", {h, l}, busy, {m_hi, m_lo});
    end
  endtask

  task automatic test_random;
    logic [5:0] fs [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    logic [5:0] f;
    logic [31:0] rs, rt, h, l, exp_rd;
    logic c, exp_st;
    int k, nb, exp_nb;
    for (int i = 0; i < 40; i++) begin
      f = fs[$urandom_range(0, 7)];
      k = $urandom_range(0, 3);
      rs = $urandom;
      rt = (k == 0) ? 32'd0 : (k == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      c = ($urandom_range(0, 3) == 0);
      exp_st = (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) && !c;
      exp_nb = !exp_st ? 0 : (f == F_DIV || f == F_DIVU) ? 10 : 5;
      exp_rd = (f == F_MFHI) ? m_hi : (f == F_MFLO) ? m_lo : 32'd0;
      drive(enc(f), rs, rt, c);
      n_run++;
      if ({is_md, start, md_rdata} !== {1'b1, exp_st, exp_rd}) begin
        n_fail++; $display("FAIL rand_comb: f=%h got %h expected %h", f, {is_md, start, md_rdata}, {1'b1, exp_st, exp_rd});
      end
      if (!c) model_md(f, rs, rt);
      wait_idle(nb);
      n_run++;
      if (nb != exp_nb) begin n_fail++; $display("FAIL rand_busy: f=%h got %0d expected %0d", f, nb, exp_nb); end
    end
    read_hilo(h, l);
    n_run++;
    if ({h, l} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL rand_hilo: got %h expected %h", {h, l}, {m_hi, m_lo}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_mthi_mtlo;
    test_cancel;
    test_reset_busy;
    test_nonmd;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
